// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding and grant-wait counter width for mem_responder.
package mem_responder_pkg;
  localparam int CTR_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_responder_gnt_ctr.sv
// mem_responder_gnt_ctr: counts cycles a request has been held without grant; clears on i_clr.
module mem_responder_gnt_ctr
  import mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_cnt
);
  logic [CTR_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= i_clr ? '0 : i_inc ? r_cnt + 1'b1 : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding req/gnt/rvalid responder in front of a synchronous RAM.
// Define MEM_RESPONDER_ERR_EN to answer out-of-window addresses with err_o instead of wrapping.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RAM_SIZE   = 32768,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0010_0000,
  parameter int                    GNT_WAIT   = 0
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
  localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(RAM_SIZE - 1);
  state_t                r_state, w_next;
  logic [CTR_W-1:0]      w_cnt;
  logic [CTR_W:0]        w_cnt_now;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_gnt, w_ram_ok, r_rd, r_err;
  mem_responder_gnt_ctr u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (~req_i | w_gnt),
    .i_inc (req_i & ~w_gnt),
    .o_cnt (w_cnt)
  );
  // Counter is 0 outside WAIT, so w_cnt_now is the 1-based index of the current request cycle.
  assign w_cnt_now = {1'b0, w_cnt} + 1'b1;
  assign w_gnt     = rst_n & req_i & (GNT_WAIT == 0 || w_cnt_now >= (CTR_W+1)'(GNT_WAIT));
  assign w_off     = addr_i - BASE_ADDR;
`ifdef MEM_RESPONDER_ERR_EN
  assign w_ram_ok  = w_off < ADDR_WIDTH'(RAM_SIZE);
`else
  assign w_ram_ok  = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb w_next = w_gnt ? RESP : req_i ? WAIT : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd  <= 1'b0;
      r_err <= 1'b0;
    end else if (w_gnt) begin
      r_rd  <= ~we_i;
      r_err <= ~w_ram_ok;
    end
  always_comb begin
    gnt_o       = w_gnt;
    ram_en_o    = w_gnt & w_ram_ok;
    ram_we_o    = w_gnt & we_i;
    ram_be_o    = be_i;
    ram_wdata_o = wdata_i;
    ram_addr_o  = w_off & MASK;
    rvalid_o    = r_state == RESP;
    rdata_o     = (rvalid_o && r_rd && !r_err) ? ram_rdata_i : '0;
`ifdef MEM_RESPONDER_ERR_EN
    err_o       = rvalid_o & r_err;
`else
    err_o       = 1'b0;
`endif
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder with GNT_WAIT=0 and GNT_WAIT=3 instances.
module tb_mem_responder;
  typedef struct {logic [31:0] d; logic e;} rsp_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic        req0 = 0, we0 = 0, gnt0, rv0, err0, en0, rwe0;
  logic [31:0] addr0 = 0, wdata0 = 0, rdata0, raddr0, rwdata0, rrdata0;
  logic [3:0]  be0 = 0, rbe0;
  logic        req3 = 0, we3 = 0, gnt3, rv3, err3, en3, rwe3;
  logic [31:0] addr3 = 0, wdata3 = 0, rdata3, raddr3, rwdata3;
  logic [31:0] rrdata3 = 32'hC0DE_0003;
  logic [3:0]  be3 = 0, rbe3;
  logic [31:0] mem [0:8191];
  int checks = 0, failures = 0;
  rsp_t q0[$], q3[$];

  mem_responder dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .gnt_o(gnt0), .rvalid_o(rv0), .addr_i(addr0),
    .we_i(we0), .be_i(be0), .wdata_i(wdata0), .rdata_o(rdata0), .err_o(err0),
    .ram_en_o(en0), .ram_addr_o(raddr0), .ram_we_o(rwe0), .ram_be_o(rbe0),
    .ram_wdata_o(rwdata0), .ram_rdata_i(rrdata0));
  mem_responder #(.GNT_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req3), .gnt_o(gnt3), .rvalid_o(rv3), .addr_i(addr3),
    .we_i(we3), .be_i(be3), .wdata_i(wdata3), .rdata_o(rdata3), .err_o(err3),
    .ram_en_o(en3), .ram_addr_o(raddr3), .ram_we_o(rwe3), .ram_be_o(rbe3),
    .ram_wdata_o(rwdata3), .ram_rdata_i(rrdata3));

  always @(posedge clk)
    if (en0) begin
      for (int i = 0; i < 4; i++)
        if (rwe0 && rbe0[i]) mem[raddr0[14:2]][8*i +: 8] <= rwdata0[8*i +: 8];
      rrdata0 <= mem[raddr0[14:2]];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rsp_t r;
    #2;
    if (rv0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rvalid0 actual=1 expected=0");
      end else begin
        r = q0.pop_front();
        chk("rdata0", rdata0, r.d);
        chk("err0", 32'(err0), 32'(r.e));
      end
    end
  end

  always @(posedge clk) begin
    rsp_t r;
    #2;
    if (rv3) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rvalid3 actual=1 expected=0");
      end else begin
        r = q3.pop_front();
        chk("rdata3", rdata3, r.d);
        chk("err3", 32'(err3), 32'(r.e));
      end
    end
  end

  task automatic go0(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e, input logic exp_en, input logic [31:0] exp_a);
    rsp_t r;
    @(negedge clk);
    req0 = 1; addr0 = a; we0 = w; be0 = b; wdata0 = wd;
    #1;
    chk("gnt0", 32'(gnt0), 1);
    chk("ram_en0", 32'(en0), 32'(exp_en));
    if (exp_en) begin
      chk("ram_addr0", raddr0, exp_a);
      chk("ram_we0", 32'(rwe0), 32'(w));
      chk("ram_be0", 32'(rbe0), 32'(b));
    end
    r.d = exp_d; r.e = exp_e;
    q0.push_back(r);
  endtask

  task automatic idle0();
    @(negedge clk);
    req0 = 0;
  endtask

  initial begin
    rsp_t r;
    for (int i = 0; i < 8192; i++) mem[i] = 0;
    mem[1]    = 32'h0000_0444;
    mem[128]  = 32'hAAAA_0200;
    mem[192]  = 32'hBBBB_0300;
    req0 = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt0), 0);
    chk("rst_rvalid", 32'(rv0), 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_ram_en", 32'(en0), 0);
    chk("rst_ram_we", 32'(rwe0), 0);
    req0 = 0;
    @(negedge clk);
    rst_n = 1;
    go0(32'h0010_0000, 1, 4'hF, 32'h1234_ABCD, 0, 0, 1, 0);
    idle0();
    go0(32'h0010_0000, 0, 4'hF, 0, 32'h1234_ABCD, 0, 1, 0);
    idle0();
    go0(32'h0010_0000, 1, 4'b0011, 32'hFFFF_5678, 0, 0, 1, 0);
    idle0();
    go0(32'h0010_0000, 0, 4'hF, 0, 32'h1234_5678, 0, 1, 0);
    go0(32'h0010_0200, 1, 4'b0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h200);
    go0(32'h0010_0200, 0, 4'hF, 0, 32'hAAAA_0200, 0, 1, 32'h200);
    go0(32'h0010_0300, 0, 4'hF, 0, 32'hBBBB_0300, 0, 1, 32'h300);
    idle0();
`ifdef MEM_RESPONDER_ERR_EN
    go0(32'h0000_0004, 0, 4'hF, 0, 0, 1, 0, 0);
`else
    go0(32'h0000_0004, 0, 4'hF, 0, 32'h0000_0444, 0, 1, 4);
`endif
    idle0();
    @(negedge clk);
    req3 = 1; addr3 = 32'h0010_0008; we3 = 0; be3 = 4'hF;
    #1;
    chk("abort_gnt_c1", 32'(gnt3), 0);
    chk("abort_en_c1", 32'(en3), 0);
    @(negedge clk);
    #1;
    chk("abort_gnt_c2", 32'(gnt3), 0);
    chk("abort_en_c2", 32'(en3), 0);
    @(negedge clk);
    req3 = 0;
    #1;
    chk("abort_gnt_drop", 32'(gnt3), 0);
    repeat (3) @(negedge clk);
    req3 = 1;
    #1;
    chk("wait_gnt_c1", 32'(gnt3), 0);
    @(negedge clk);
    #1;
    chk("wait_gnt_c2", 32'(gnt3), 0);
    @(negedge clk);
    #1;
    chk("wait_gnt_c3", 32'(gnt3), 1);
    chk("wait_en_c3", 32'(en3), 1);
    chk("wait_addr_c3", raddr3, 32'h8);
    r.d = 32'hC0DE_0003; r.e = 0;
    q3.push_back(r);
    @(negedge clk);
    req3 = 0;
    @(negedge clk);
    req0 = 1; addr0 = 32'h0010_0200; we0 = 0; be0 = 4'hF;
    #1;
    chk("rst_case_gnt", 32'(gnt0), 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_rvalid", 32'(rv0), 0);
    chk("midrst_rdata", rdata0, 0);
    chk("midrst_gnt", 32'(gnt0), 0);
    chk("midrst_ram_en", 32'(en0), 0);
    chk("midrst_ram_we", 32'(rwe0), 0);
    chk("midrst_err", 32'(err0), 0);
    @(negedge clk);
    req0 = 0;
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
